// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline stage register.
//   state_e     : occupancy state of a stage (EMPTY / ONE / TWO entries held)
//   BUBBLE_CTRL : control bit value of a bubble (replicated to CTRL_W)
//   OCC_W       : width of the occupancy count output
//   occ_of()    : maps a state to its entry count
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // A bubble carries all-zero control bits, which decode as a NOP downstream.
  localparam logic BUBBLE_CTRL = 1'b0;

  localparam int OCC_W = 2;

  // Number of entries held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    case (s)
      EMPTY:   occ_of = 2'd0;
      ONE:     occ_of = 2'd1;
      TWO:     occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// -----------------------------------------------------------------------------
// pipe_entry
// One storage slot of a pipeline stage: control + payload register with a
// load enable and a synchronous reset that clears both fields.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous active-high reset, clears the slot
//   i_load  : capture i_ctrl/i_data on the rising edge
//   i_ctrl  : control bits to store
//   i_data  : payload to store
//   o_ctrl  : stored control bits
//   o_data  : stored payload
// -----------------------------------------------------------------------------
module pipe_entry #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Slot storage: reset clears, load captures, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ctrl <= {CTRL_W{1'b0}};
      r_data <= {DATA_W{1'b0}};
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic pipeline stage register with valid/ready handshake, optional
// two-entry skid buffer and a flush that turns the stage into a bubble.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : upstream handshake
//   in_ctrl / in_data    : upstream control bits and payload
//   flush                : drop every held and incoming entry
//   out_valid / out_ready: downstream handshake
//   out_ctrl / out_data  : head entry (out_ctrl forced to 0 while invalid)
//   occ                  : number of entries held (0..2)
// With SKID=1 in_ready is a pure register decode, so there is no
// combinational path from out_ready to in_ready. With SKID=0 the stage holds
// a single entry and in_ready looks through to out_ready.
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occ
);

  state_e            r_state;
  logic              r_valid;
  logic              r_full;
  logic [OCC_W-1:0]  r_occ;

  state_e            w_state_nxt;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_ld;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data_d;
  logic [CTRL_W-1:0] w_main_ctrl_q;
  logic [DATA_W-1:0] w_main_data_q;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_valid & out_ready;

  // Next state and main-slot load enable. Flush wins over every transfer;
  // a same-cycle out_fire has already been taken by downstream.
  always_comb begin
    w_state_nxt = r_state;
    w_main_ld   = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ONE;
            w_main_ld   = 1'b1;
          end else begin
            w_state_nxt = EMPTY;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_state_nxt = ONE;
            w_main_ld   = 1'b1;
          end else if (w_in_fire) begin
            // Only reachable with a skid slot: new entry parks behind main.
            w_state_nxt = (SKID != 0) ? TWO : ONE;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end else begin
            w_state_nxt = ONE;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            w_state_nxt = ONE;
            w_main_ld   = 1'b1;
          end else begin
            w_state_nxt = TWO;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  // State register plus registered decodes used directly as outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
      r_occ   <= {OCC_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != EMPTY);
      r_full  <= (w_state_nxt == TWO);
      r_occ   <= occ_of(w_state_nxt);
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic              w_skid_ld;
      logic [CTRL_W-1:0] w_skid_ctrl_q;
      logic [DATA_W-1:0] w_skid_data_q;

      assign w_skid_ld = ~flush & (r_state == ONE) & w_in_fire & ~w_out_fire;

      pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .i_clk   (clk),
        .i_reset (reset),
        .i_load  (w_skid_ld),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_ctrl  (w_skid_ctrl_q),
        .o_data  (w_skid_data_q)
      );

      // In TWO the only way main reloads is by promoting the skid entry,
      // which keeps strict FIFO order.
      assign w_main_ctrl_d = (r_state == TWO) ? w_skid_ctrl_q : in_ctrl;
      assign w_main_data_d = (r_state == TWO) ? w_skid_data_q : in_data;

      // Registered decode only; out_ready does not reach in_ready.
      assign in_ready = ~reset & ~r_full;
    end else begin : g_noskid
      assign w_main_ctrl_d = in_ctrl;
      assign w_main_data_d = in_data;

      // Single slot: accept when empty or when the held entry leaves now.
      assign in_ready = ~reset & (~r_valid | out_ready);
    end
  endgenerate

  pipe_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_main_ld),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_ctrl  (w_main_ctrl_q),
    .o_data  (w_main_data_q)
  );

  assign out_valid = r_valid;
  // Stale control bits are never exposed: an invalid stage shows a bubble.
  assign out_ctrl  = r_valid ? w_main_ctrl_q : {CTRL_W{BUBBLE_CTRL}};
  assign out_data  = w_main_data_q;
  assign occ       = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives a SKID=1 and a SKID=0 instance with identical stimulus and compares
// both against queue-based reference models of an elastic FIFO stage.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_ready;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [DW-1:0] out_data1, out_data0;
  logic [1:0]    occ1, occ0;

  int n_cmp = 0;
  int n_err = 0;

  typedef logic [CW+DW-1:0] ent_t;
  ent_t q1[$];
  ent_t q0[$];
  logic exp_rdy1, exp_rdy0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
    .out_data(out_data1), .occ(occ1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
    .out_data(out_data0), .occ(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [CW-1:0] ic,
                       input logic [DW-1:0] id, input logic fl, input logic ordy);
    reset = rst; in_valid = iv; in_ctrl = ic; in_data = id; flush = fl; out_ready = ordy;
  endtask

  // One clock: compare outputs with the models, then advance the models.
  task automatic cycle(input bit do_chk);
    bit f_in, f_out;
    #1;
    exp_rdy1 = !reset && (q1.size() < 2);
    exp_rdy0 = !reset && (q0.size() == 0 || out_ready);
    if (do_chk) begin
      chk_eq("rdy1", 64'(in_ready1), 64'(exp_rdy1));
      chk_eq("vld1", 64'(out_valid1), 64'(q1.size() != 0));
      chk_eq("occ1", 64'(occ1), 64'(q1.size()));
      chk_eq("ctl1", 64'(out_ctrl1), (q1.size() != 0) ? 64'(q1[0][CW+DW-1:DW]) : 64'd0);
      if (q1.size() != 0) chk_eq("dat1", 64'(out_data1), 64'(q1[0][DW-1:0]));
      chk_eq("rdy0", 64'(in_ready0), 64'(exp_rdy0));
      chk_eq("vld0", 64'(out_valid0), 64'(q0.size() != 0));
      chk_eq("occ0", 64'(occ0), 64'(q0.size()));
      chk_eq("ctl0", 64'(out_ctrl0), (q0.size() != 0) ? 64'(q0[0][CW+DW-1:DW]) : 64'd0);
      if (q0.size() != 0) chk_eq("dat0", 64'(out_data0), 64'(q0[0][DW-1:0]));
    end
    @(posedge clk);
    if (reset) begin
      q1.delete();
      q0.delete();
    end else begin
      f_in  = in_valid && exp_rdy1;
      f_out = (q1.size() != 0) && out_ready;
      if (f_out) void'(q1.pop_front());
      if (flush) q1.delete();
      else if (f_in) q1.push_back({in_ctrl, in_data});
      f_in  = in_valid && exp_rdy0;
      f_out = (q0.size() != 0) && out_ready;
      if (f_out) void'(q0.pop_front());
      if (flush) q0.delete();
      else if (f_in) q0.push_back({in_ctrl, in_data});
    end
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 1'b1, 16'h0000, 32'hAA, 1'b0, 1'b0);
    @(negedge clk);

    // 1: reset held two cycles with valid input
    cycle(1'b0);
    cycle(1'b1);
    drive(1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b1);
    #1;
    chk_eq("t1_rdy1", 64'(in_ready1), 64'd1);
    chk_eq("t1_occ1", 64'(occ1), 64'd0);
    cycle(1'b1);

    // 2: streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 16'(i + 16'h10), 32'(i), 1'b0, 1'b1);
      cycle(1'b1);
    end
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1);
    cycle(1'b1);

    // 3: fill the skid buffer, then drain
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 16'(i + 16'h20), 32'(i), 1'b0, 1'b0);
      cycle(1'b1);
    end
    #1;
    chk_eq("t3_occ1", 64'(occ1), 64'd2);
    chk_eq("t3_rdy1", 64'(in_ready1), 64'd0);
    chk_eq("t3_dat1", 64'(out_data1), 64'd1);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1);

    // 4: flush while full, with a same-cycle input
    drive(1'b0, 1'b1, 16'h0031, 32'h31, 1'b0, 1'b0);
    cycle(1'b1);
    drive(1'b0, 1'b1, 16'h0032, 32'h32, 1'b0, 1'b0);
    cycle(1'b1);
    drive(1'b0, 1'b1, 16'hFFFF, 32'h33, 1'b1, 1'b0);
    cycle(1'b1);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk_eq("t4_occ1", 64'(occ1), 64'd0);
    chk_eq("t4_vld1", 64'(out_valid1), 64'd0);
    chk_eq("t4_ctl1", 64'(out_ctrl1), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1);

    // 5: single-entry mode, stall then release
    drive(1'b0, 1'b1, 16'h0007, 32'h7, 1'b0, 1'b0);
    cycle(1'b1);
    drive(1'b0, 1'b1, 16'h0008, 32'h8, 1'b0, 1'b0);
    #1;
    chk_eq("t5_rdy0", 64'(in_ready0), 64'd0);
    chk_eq("t5_dat0", 64'(out_data0), 64'd7);
    cycle(1'b1);
    drive(1'b0, 1'b1, 16'h0008, 32'h8, 1'b0, 1'b1);
    #1;
    chk_eq("t5_rdy0_rel", 64'(in_ready0), 64'd1);
    cycle(1'b1);
    chk_eq("t5_vld0", 64'(out_valid0), 64'd1);
    chk_eq("t5_nxt0", 64'(out_data0), 64'd8);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1);

    // 6: reset while two entries are held
    drive(1'b0, 1'b1, 16'h0041, 32'h11, 1'b0, 1'b0);
    cycle(1'b1);
    drive(1'b0, 1'b1, 16'h0042, 32'h22, 1'b0, 1'b0);
    cycle(1'b1);
    #1;
    chk_eq("t6_pre_occ1", 64'(occ1), 64'd2);
    drive(1'b1, 1'b1, 16'h0043, 32'h33, 1'b0, 1'b0);
    cycle(1'b1);
    #1;
    chk_eq("t6_occ1", 64'(occ1), 64'd0);
    chk_eq("t6_dat1", 64'(out_data1), 64'd0);
    chk_eq("t6_ctl1", 64'(out_ctrl1), 64'd0);
    chk_eq("t6_dat0", 64'(out_data0), 64'd0);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(3) != 0), 16'($urandom),
            32'($urandom), ($urandom_range(15) == 0), ($urandom_range(2) != 0));
      cycle(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
